// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer and flush-to-NOP.
// Optional saturating stall counter is built only when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg #(
    parameter int                DATA_W    = 32,
    parameter int                PC_W      = 32,
    parameter logic [DATA_W-1:0] NOP_VALUE = '0,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [PC_W-1:0]   r_main_pc;
    logic [DATA_W-1:0] r_main_data;
    logic [PC_W-1:0]   r_skid_pc;
    logic [DATA_W-1:0] r_skid_data;

    logic w_push;
    logic w_pop;

    assign w_push = in_valid & r_in_ready;
    assign w_pop  = r_out_valid & out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_main_pc   <= '0;
            r_main_data <= NOP_VALUE;
            r_skid_pc   <= '0;
            r_skid_data <= '0;
        end else if (flush) begin
            // PC of the incoming beat stays visible for redirect/exception recovery.
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_main_data <= NOP_VALUE;
            r_skid_pc   <= '0;
            r_skid_data <= '0;
            if (in_valid) begin
                r_main_pc <= in_pc;
            end
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_push) begin
                        r_state     <= ONE;
                        r_out_valid <= 1'b1;
                        r_main_pc   <= in_pc;
                        r_main_data <= in_data;
                    end
                end
                ONE: begin
                    if (w_push && w_pop) begin
                        r_main_pc   <= in_pc;
                        r_main_data <= in_data;
                    end else if (w_push) begin
                        r_state     <= TWO;
                        r_in_ready  <= 1'b0;
                        r_skid_pc   <= in_pc;
                        r_skid_data <= in_data;
                    end else if (w_pop) begin
                        r_state     <= EMPTY;
                        r_out_valid <= 1'b0;
                        r_main_data <= NOP_VALUE;
                    end
                end
                TWO: begin
                    if (w_pop) begin
                        r_state     <= ONE;
                        r_in_ready  <= 1'b1;
                        r_main_pc   <= r_skid_pc;
                        r_main_data <= r_skid_data;
                        r_skid_pc   <= '0;
                        r_skid_data <= '0;
                    end
                end
                default: begin
                    r_state     <= EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_main_data <= NOP_VALUE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_pc    = r_main_pc;
    assign out_data  = r_main_data;

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;

    // Saturates instead of wrapping; flush deliberately leaves it alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (r_out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = '0;
`endif

endmodule
